// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings,
// FSM state type, widths and the fault decode used at request acceptance.
package riscv_mem_pkg;

  localparam int XLEN   = 64;
  localparam int ADDR_W = 64;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } lsu_state_e;

  // funct3[1:0] encodes the access size for both loads and stores.
  function automatic logic access_fault(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [2:0] offset);
    logic illegal;
    logic misaligned;
    illegal = (funct3 == 3'b111) || (is_store && funct3[2]);
    case (funct3[1:0])
      2'b01:   misaligned = offset[0];
      2'b10:   misaligned = (offset[1:0] != 2'b00);
      2'b11:   misaligned = (offset != 3'b000);
      default: misaligned = 1'b0;
    endcase
    return illegal || misaligned;
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction: selects the little-endian lane at the
// byte offset within a doubleword and sign- or zero-extends it per funct3.
module load_align
  import riscv_mem_pkg::*;
(
  input  logic [XLEN-1:0] dword,
  input  logic [2:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  assign shifted = dword >> {offset, 3'b000};

  always_comb begin
    result = '0;
    case (funct3)
      F3_LB:   result = {{56{shifted[7]}}, shifted[7:0]};
      F3_LH:   result = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   result = {{32{shifted[31]}}, shifted[31:0]};
      F3_LD:   result = shifted;
      F3_LBU:  result = {56'd0, shifted[7:0]};
      F3_LHU:  result = {48'd0, shifted[15:0]};
      F3_LWU:  result = {32'd0, shifted[31:0]};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: maps RV64 byte..doubleword accesses onto a
// doubleword-only memory, using read-modify-write for narrow stores.
module load_store_unit
  import riscv_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [XLEN-1:0]   mem_write_data,
  input  logic [XLEN-1:0]   mem_read_data
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready depends only on state and rst_n, and
  // the requester must hold req_valid and its payload until that edge.

  lsu_state_e        state_q;
  lsu_state_e        state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              is_store_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   merged_q;
  logic [XLEN-1:0]   resp_rdata_q;
  logic              resp_fault_q;
  logic              req_fault;
  logic              accept;
  logic [XLEN-1:0]   load_result;

  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] old_dword,
                                                  input logic [XLEN-1:0] wdata,
                                                  input logic [2:0]      offset,
                                                  input logic [1:0]      size);
    logic [XLEN-1:0] mask;
    logic [5:0]      shamt;
    shamt = {offset, 3'b000};
    case (size)
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      2'b10:   mask = 64'h0000_0000_FFFF_FFFF;
      default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    mask = mask << shamt;
    return (old_dword & ~mask) | ((wdata << shamt) & mask);
  endfunction

  assign req_fault = access_fault(req_is_store, req_funct3, req_addr[2:0]);
  assign accept    = req_valid && req_ready;

  load_align u_load_align (
    .dword  (mem_read_data),
    .offset (addr_q[2:0]),
    .funct3 (funct3_q),
    .result (load_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_fault)                  state_d = S_DONE;
          else if (!req_is_store)         state_d = S_LOAD;
          else if (req_funct3 == F3_LD)   state_d = S_WRITE;
          else                            state_d = S_RMW_RD;
        end
      end
      S_LOAD:   state_d = S_DONE;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      is_store_q   <= 1'b0;
      wdata_q      <= '0;
      merged_q     <= '0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q       <= req_addr;
        funct3_q     <= req_funct3;
        is_store_q   <= req_is_store;
        wdata_q      <= req_wdata;
        merged_q     <= req_wdata;
        resp_rdata_q <= '0;
        resp_fault_q <= req_fault;
      end
      if (state_q == S_LOAD && !is_store_q) begin
        resp_rdata_q <= load_result;
      end
      if (state_q == S_RMW_RD) begin
        merged_q <= store_merge(mem_read_data, wdata_q, addr_q[2:0], funct3_q[1:0]);
      end
    end
  end

  // Strobes are gated by rst_n so an access caught by reset never reaches memory.
  assign req_ready      = rst_n && (state_q == S_IDLE);
  assign resp_valid     = rst_n && (state_q == S_DONE);
  assign mem_read       = rst_n && ((state_q == S_LOAD) || (state_q == S_RMW_RD));
  assign mem_write      = rst_n && (state_q == S_WRITE);
  assign mem_address    = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem_write_data = merged_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_fault     = resp_fault_q;

endmodule
